// File: rtl/irq_timer_if.sv
// Data-memory bus slice seen by the interval timer, plus the IRQ/ack pair to the control unit.
// The CPU side drives the master modport; the timer uses the slave modport.
interface irq_timer_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        MemRd;
   logic        MemWr;
   logic        irq_ack;
   logic        IRQ;

   modport master (
      output addr,
      output wdata,
      output MemRd,
      output MemWr,
      output irq_ack,
      input  rdata,
      input  IRQ
   );

   modport slave (
      input  addr,
      input  wdata,
      input  MemRd,
      input  MemWr,
      input  irq_ack,
      output rdata,
      output IRQ
   );
endinterface

// File: rtl/irq_timer.sv
// Memory-mapped interval timer: TH reload, TL up-counter, TCON {ST, IE, EN}.
// IRQ is held until acked, then masked by in_service until software clears ST.
module irq_timer #(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
   input logic        clk,
   input logic        reset,
   irq_timer_if.slave bus
);

   logic [31:0] th_q, th_d;
   logic [31:0] tl_q, tl_d;
   logic        en_q, en_d;
   logic        ie_q, ie_d;
   logic        st_q, st_d;
   logic        in_service_q, in_service_d;

   logic sel_th, sel_tl, sel_tcon;
   logic wr_th, wr_tl, wr_tcon;
   logic ovf, ovf_set;

   // Exact byte-address match; unaligned and out-of-window addresses select nothing.
   assign sel_th   = (bus.addr == BASE_ADDR);
   assign sel_tl   = (bus.addr == BASE_ADDR + 32'h4);
   assign sel_tcon = (bus.addr == BASE_ADDR + 32'h8);

   assign wr_th   = bus.MemWr & sel_th;
   assign wr_tl   = bus.MemWr & sel_tl;
   assign wr_tcon = bus.MemWr & sel_tcon;

   // A TL write replaces counting for the cycle, so it also suppresses overflow.
   assign ovf     = en_q & ~wr_tl & (tl_q == 32'hFFFF_FFFF);
   assign ovf_set = ovf & ie_q;

   always_comb begin
      th_d         = th_q;
      tl_d         = tl_q;
      en_d         = en_q;
      ie_d         = ie_q;
      st_d         = st_q;
      in_service_d = in_service_q;

      if (wr_th) begin
         th_d = bus.wdata;
      end

      if (wr_tl) begin
         tl_d = bus.wdata;
      end else if (en_q) begin
         tl_d = ovf ? th_q : tl_q + 32'd1;
      end

      if (ovf_set) begin
         st_d = 1'b1;
      end

      // A pending overflow survives a simultaneous software clear of ST.
      if (wr_tcon) begin
         en_d = bus.wdata[0];
         ie_d = bus.wdata[1];
         st_d = bus.wdata[2] | ovf_set;
      end

      if (!st_d || !ie_d) begin
         in_service_d = 1'b0;
      end else if (bus.irq_ack) begin
         in_service_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         th_q         <= '0;
         tl_q         <= '0;
         en_q         <= 1'b0;
         ie_q         <= 1'b0;
         st_q         <= 1'b0;
         in_service_q <= 1'b0;
      end else begin
         th_q         <= th_d;
         tl_q         <= tl_d;
         en_q         <= en_d;
         ie_q         <= ie_d;
         st_q         <= st_d;
         in_service_q <= in_service_d;
      end
   end

   always_comb begin
      bus.rdata = '0;
      if (bus.MemRd) begin
         if (sel_th) begin
            bus.rdata = th_q;
         end else if (sel_tl) begin
            bus.rdata = tl_q;
         end else if (sel_tcon) begin
            bus.rdata = {29'b0, st_q, ie_q, en_q};
         end
      end
   end

   assign bus.IRQ = ie_q & st_q & ~in_service_q;

endmodule

// File: tb/tb_irq_timer.sv
// Directed bench for irq_timer: a vector table of bus cycles with expected rdata/IRQ,
// followed by hand-written reset sequences.
module tb_irq_timer;

   localparam logic [31:0] BASE   = 32'h4000_0000;
   localparam logic [31:0] A_TH   = BASE;
   localparam logic [31:0] A_TL   = BASE + 32'h4;
   localparam logic [31:0] A_TCON = BASE + 32'h8;
   localparam logic [31:0] A_C    = BASE + 32'hC;
   localparam logic [31:0] A_UNAL = BASE + 32'h2;

   logic clk;
   logic reset;

   irq_timer_if bus ();

   irq_timer #(
      .BASE_ADDR(BASE)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic        rd;
      logic        ack;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   task automatic add(input logic wr, input logic rd, input logic ack, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_irq);
      vec_t v;
      v.wr = wr; v.rd = rd; v.ack = ack; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = exp_rdata; v.exp_irq = exp_irq;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic drive(input logic wr, input logic rd, input logic ack, input logic [31:0] addr,
                        input logic [31:0] wdata);
      bus.MemWr   = wr;
      bus.MemRd   = rd;
      bus.irq_ack = ack;
      bus.addr    = addr;
      bus.wdata   = wdata;
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      reset = 1'b1;

      // Reset state, checked while reset is still asserted.
      #2;
      check("reset irq", {31'b0, bus.IRQ}, 32'd0);
      drive(1'b0, 1'b1, 1'b0, A_TH, '0);   #1 check("reset th", bus.rdata, 32'd0);
      drive(1'b0, 1'b1, 1'b0, A_TL, '0);   #1 check("reset tl", bus.rdata, 32'd0);
      drive(1'b0, 1'b1, 1'b0, A_TCON, '0); #1 check("reset tcon", bus.rdata, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      //  wr    rd    ack   addr    wdata          rdata          irq
      // Basic overflow, period 4.
      add(1'b1, 1'b0, 1'b0, A_TH,   32'hFFFF_FFFC, 32'h0,         1'b0);
      add(1'b1, 1'b0, 1'b0, A_TL,   32'hFFFF_FFFC, 32'h0,         1'b0);
      add(1'b1, 1'b0, 1'b0, A_TCON, 32'h3,         32'h0,         1'b0);
      add(1'b0, 1'b1, 1'b0, A_TL,   32'h0,         32'hFFFF_FFFC, 1'b0);
      add(1'b0, 1'b1, 1'b0, A_TL,   32'h0,         32'hFFFF_FFFD, 1'b0);
      add(1'b0, 1'b1, 1'b0, A_TL,   32'h0,         32'hFFFF_FFFE, 1'b0);
      add(1'b0, 1'b1, 1'b0, A_TL,   32'h0,         32'hFFFF_FFFF, 1'b0);
      add(1'b0, 1'b1, 1'b0, A_TL,   32'h0,         32'hFFFF_FFFC, 1'b1);
      add(1'b0, 1'b1, 1'b0, A_TCON, 32'h0,         32'h7,         1'b1);
      add(1'b0, 1'b1, 1'b0, A_TL,   32'h0,         32'hFFFF_FFFE, 1'b1);
      add(1'b0, 1'b1, 1'b0, A_TL,   32'h0,         32'hFFFF_FFFF, 1'b1);
      add(1'b0, 1'b1, 1'b0, A_TL,   32'h0,         32'hFFFF_FFFC, 1'b1);
      // Ack masks IRQ across a later overflow; clearing ST re-arms it.
      add(1'b0, 1'b1, 1'b1, A_TL,   32'h0,         32'hFFFF_FFFD, 1'b1);
      add(1'b0, 1'b1, 1'b0, A_TCON, 32'h0,         32'h7,         1'b0);
      add(1'b0, 1'b1, 1'b0, A_TL,   32'h0,         32'hFFFF_FFFF, 1'b0);
      add(1'b0, 1'b1, 1'b0, A_TL,   32'h0,         32'hFFFF_FFFC, 1'b0);
      add(1'b1, 1'b0, 1'b0, A_TCON, 32'h3,         32'h0,         1'b0);
      add(1'b0, 1'b1, 1'b0, A_TCON, 32'h0,         32'h3,         1'b0);
      add(1'b0, 1'b1, 1'b0, A_TL,   32'h0,         32'hFFFF_FFFF, 1'b0);
      add(1'b0, 1'b1, 1'b0, A_TCON, 32'h0,         32'h7,         1'b1);
      // ST clear drops IRQ; TCON write on the overflow edge keeps ST.
      add(1'b1, 1'b0, 1'b0, A_TCON, 32'h3,         32'h0,         1'b1);
      add(1'b0, 1'b1, 1'b0, A_TCON, 32'h0,         32'h3,         1'b0);
      add(1'b1, 1'b0, 1'b0, A_TCON, 32'h3,         32'h0,         1'b0);
      add(1'b0, 1'b1, 1'b0, A_TCON, 32'h0,         32'h7,         1'b1);
      // Ack together with an ST clear leaves in_service clear.
      add(1'b1, 1'b0, 1'b1, A_TCON, 32'h3,         32'h0,         1'b1);
      add(1'b0, 1'b1, 1'b0, A_TCON, 32'h0,         32'h3,         1'b0);
      add(1'b0, 1'b1, 1'b0, A_TL,   32'h0,         32'hFFFF_FFFF, 1'b0);
      add(1'b0, 1'b1, 1'b0, A_TL,   32'h0,         32'hFFFF_FFFC, 1'b1);
      // TL write at FFFF_FFFF wins over reload.
      add(1'b0, 1'b1, 1'b0, A_TL,   32'h0,         32'hFFFF_FFFD, 1'b1);
      add(1'b0, 1'b1, 1'b0, A_TCON, 32'h0,         32'h7,         1'b1);
      add(1'b1, 1'b0, 1'b0, A_TL,   32'h5,         32'h0,         1'b1);
      add(1'b0, 1'b1, 1'b0, A_TL,   32'h0,         32'h5,         1'b1);
      add(1'b0, 1'b1, 1'b0, A_TL,   32'h0,         32'h6,         1'b1);
      // Decode: reserved and unaligned addresses, read strobe low.
      add(1'b1, 1'b0, 1'b0, A_C,    32'hDEAD_BEEF, 32'h0,         1'b1);
      add(1'b1, 1'b0, 1'b0, A_UNAL, 32'hDEAD_BEEF, 32'h0,         1'b1);
      add(1'b0, 1'b1, 1'b0, A_C,    32'h0,         32'h0,         1'b1);
      add(1'b0, 1'b1, 1'b0, A_UNAL, 32'h0,         32'h0,         1'b1);
      add(1'b0, 1'b1, 1'b0, A_TH,   32'h0,         32'hFFFF_FFFC, 1'b1);
      add(1'b0, 1'b0, 1'b0, A_TH,   32'h0,         32'h0,         1'b1);
      add(1'b0, 1'b1, 1'b0, A_TCON, 32'h0,         32'h7,         1'b1);
      add(1'b0, 1'b1, 1'b0, A_TL,   32'h0,         32'hE,         1'b1);
      // IE=0: reload continues, ST and IRQ stay low.
      add(1'b1, 1'b0, 1'b0, A_TCON, 32'h1,         32'h0,         1'b1);
      add(1'b1, 1'b0, 1'b0, A_TL,   32'hFFFF_FFFE, 32'h0,         1'b0);
      add(1'b0, 1'b1, 1'b0, A_TL,   32'h0,         32'hFFFF_FFFE, 1'b0);
      add(1'b0, 1'b1, 1'b0, A_TL,   32'h0,         32'hFFFF_FFFF, 1'b0);
      add(1'b0, 1'b1, 1'b0, A_TL,   32'h0,         32'hFFFF_FFFC, 1'b0);
      add(1'b0, 1'b1, 1'b0, A_TCON, 32'h0,         32'h1,         1'b0);
      add(1'b0, 1'b1, 1'b0, A_TCON, 32'h0,         32'h1,         1'b0);
      add(1'b0, 1'b1, 1'b0, A_TL,   32'h0,         32'hFFFF_FFFF, 1'b0);
      add(1'b0, 1'b1, 1'b0, A_TL,   32'h0,         32'hFFFF_FFFC, 1'b0);
      // Same-cycle read/write returns old TH; new TH used at the next overflow.
      add(1'b1, 1'b1, 1'b0, A_TH,   32'h10,        32'hFFFF_FFFC, 1'b0);
      add(1'b0, 1'b1, 1'b0, A_TH,   32'h0,         32'h10,        1'b0);
      add(1'b0, 1'b1, 1'b0, A_TL,   32'h0,         32'hFFFF_FFFF, 1'b0);
      add(1'b0, 1'b1, 1'b0, A_TL,   32'h0,         32'h10,        1'b0);
      // EN=0 freezes TL (the disabling edge still counts with the old EN).
      add(1'b1, 1'b0, 1'b0, A_TCON, 32'h0,         32'h0,         1'b0);
      add(1'b0, 1'b1, 1'b0, A_TL,   32'h0,         32'h12,        1'b0);
      add(1'b0, 1'b1, 1'b0, A_TL,   32'h0,         32'h12,        1'b0);
      add(1'b0, 1'b1, 1'b0, A_TCON, 32'h0,         32'h0,         1'b0);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].wr, vecs[i].rd, vecs[i].ack, vecs[i].addr, vecs[i].wdata);
         #1;
         check($sformatf("v%0d rdata", i), bus.rdata, vecs[i].exp_rdata);
         check($sformatf("v%0d irq", i), {31'b0, bus.IRQ}, {31'b0, vecs[i].exp_irq});
      end

      // Reset mid-operation: raise IRQ with the counter running, then reset between edges.
      @(negedge clk); drive(1'b1, 1'b0, 1'b0, A_TL, 32'hFFFF_FFFF);
      @(negedge clk); drive(1'b1, 1'b0, 1'b0, A_TCON, 32'h3);
      @(negedge clk); drive(1'b0, 1'b0, 1'b0, A_TH, '0);
      @(negedge clk); #1;
      check("pre-reset irq", {31'b0, bus.IRQ}, 32'd1);
      #1 reset = 1'b1;
      #1 check("async reset irq", {31'b0, bus.IRQ}, 32'd0);
      drive(1'b0, 1'b1, 1'b0, A_TL, '0);
      #1 check("async reset tl", bus.rdata, 32'd0);
      @(negedge clk); @(negedge clk); #1;
      check("reset hold tl", bus.rdata, 32'd0);
      drive(1'b0, 1'b1, 1'b0, A_TH, '0);   #1 check("reset hold th", bus.rdata, 32'd0);
      drive(1'b0, 1'b1, 1'b0, A_TCON, '0); #1 check("reset hold tcon", bus.rdata, 32'd0);
      reset = 1'b0;
      drive(1'b0, 1'b1, 1'b0, A_TL, '0);
      @(negedge clk); #1;
      check("post-reset tl", bus.rdata, 32'd0);
      check("post-reset irq", {31'b0, bus.IRQ}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
